// File: rtl/iserdes_word_aligner.sv
// rtl/iserdes_word_aligner.sv - bitslip-driven word alignment controller for a 10-bit ISERDES pair
module iserdes_word_aligner #(
    parameter logic [9:0] TRAINING_PATTERN = 10'h0f8,
    parameter int         SETTLE_CYCLES    = 4,
    parameter int         MATCH_COUNT      = 16,
    parameter int         MAX_SLIPS        = 9,
    parameter int         LOSS_THRESHOLD   = 4
) (
    input  logic        i_word_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [9:0]  i_word_in,
    output logic        o_bitslip,
    output logic        o_busy,
    output logic        o_aligned,
    output logic        o_failed,
    output logic [3:0]  o_slip_count,
    output logic [15:0] o_error_count
);
    localparam int              SW          = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]      MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [3:0]      SLIP_MAX    = 4'(MAX_SLIPS);
    localparam logic [3:0]      LOSS_LAST   = 4'(LOSS_THRESHOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_CHECK, ST_SLIP, ST_LOCKED, ST_FAILED
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_settle_cnt;
    logic [7:0]    r_match_cnt;
    logic [3:0]    r_loss_cnt;
    logic [3:0]    r_slip_count;
    logic [15:0]   r_error_count;
    logic          r_bitslip;
    logic          r_busy;
    logic          r_aligned;
    logic          r_failed;
    logic          r_armed;
    logic          w_match;
    logic          w_start_ok;

    assign w_match = (i_word_in == TRAINING_PATTERN);
    // r_armed blocks a start that arrives on the first edge after reset release
    assign w_start_ok = i_start && r_armed &&
                        (r_state inside {ST_IDLE, ST_FAILED, ST_LOCKED});

    always_ff @(posedge i_word_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= '0;
            r_match_cnt   <= '0;
            r_loss_cnt    <= '0;
            r_slip_count  <= '0;
            r_error_count <= '0;
            r_bitslip     <= 1'b0;
            r_busy        <= 1'b0;
            r_aligned     <= 1'b0;
            r_failed      <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_bitslip <= 1'b0;
            if (w_start_ok) begin
                r_state       <= ST_SETTLE;
                r_settle_cnt  <= '0;
                r_match_cnt   <= '0;
                r_loss_cnt    <= '0;
                r_slip_count  <= '0;
                r_error_count <= '0;
                r_busy        <= 1'b1;
                r_aligned     <= 1'b0;
                r_failed      <= 1'b0;
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            r_state      <= ST_CHECK;
                            r_settle_cnt <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (w_match) begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                            if (r_match_cnt == MATCH_LAST) begin
                                r_state   <= ST_LOCKED;
                                r_busy    <= 1'b0;
                                r_aligned <= 1'b1;
                            end
                        end else if (r_slip_count < SLIP_MAX) begin
                            r_state      <= ST_SLIP;
                            r_match_cnt  <= '0;
                            r_bitslip    <= 1'b1;
                            r_slip_count <= r_slip_count + 4'd1;
                        end else begin
                            r_state  <= ST_FAILED;
                            r_busy   <= 1'b0;
                            r_failed <= 1'b1;
                        end
                    end
                    ST_SLIP: begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            r_loss_cnt <= '0;
                        end else begin
                            if (r_error_count != 16'hffff)
                                r_error_count <= r_error_count + 16'd1;
                            // relock goes straight to CHECK: the lane is assumed still settled
                            if (r_loss_cnt == LOSS_LAST) begin
                                r_state      <= ST_CHECK;
                                r_loss_cnt   <= '0;
                                r_match_cnt  <= '0;
                                r_slip_count <= '0;
                                r_busy       <= 1'b1;
                                r_aligned    <= 1'b0;
                            end else begin
                                r_loss_cnt <= r_loss_cnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_bitslip     = r_bitslip;
    assign o_busy        = r_busy;
    assign o_aligned     = r_aligned;
    assign o_failed      = r_failed;
    assign o_slip_count  = r_slip_count;
    assign o_error_count = r_error_count;
endmodule

// File: tb/tb_iserdes_word_aligner.sv
// tb/tb_iserdes_word_aligner.sv - randomized bench for iserdes_word_aligner against a timeline model
module tb_iserdes_word_aligner;
    localparam logic [9:0] PAT  = 10'h0f8;
    localparam int         S    = 4;
    localparam int         M    = 16;
    localparam int         MAXS = 9;
    localparam int         T    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, bs1, busy1, al1, fail1;
    logic [9:0]  word1;
    logic [3:0]  slip1;
    logic [15:0] err1;
    logic        rst2, start2, bs2, busy2, al2, fail2;
    logic [9:0]  word2;
    logic [3:0]  slip2;
    logic [15:0] err2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_err1 = 0;
    bit inj_q[$];

    iserdes_word_aligner #(.TRAINING_PATTERN(PAT), .SETTLE_CYCLES(S), .MATCH_COUNT(M),
                           .MAX_SLIPS(MAXS), .LOSS_THRESHOLD(T)) dut1 (
        .i_word_clock(clk), .i_reset(rst1), .i_start(start1), .i_word_in(word1),
        .o_bitslip(bs1), .o_busy(busy1), .o_aligned(al1), .o_failed(fail1),
        .o_slip_count(slip1), .o_error_count(err1));

    iserdes_word_aligner #(.TRAINING_PATTERN(PAT), .SETTLE_CYCLES(S), .MATCH_COUNT(1),
                           .MAX_SLIPS(MAXS), .LOSS_THRESHOLD(15)) dut2 (
        .i_word_clock(clk), .i_reset(rst2), .i_start(start2), .i_word_in(word2),
        .o_bitslip(bs2), .o_busy(busy2), .o_aligned(al2), .o_failed(fail2),
        .o_slip_count(slip2), .o_error_count(err2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int off);
        logic [9:0] r = w;
        for (int i = 0; i < off; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    // Barrel-shifter deserializer: k slips needed to align; k > MAXS means never aligns
    function automatic logic [9:0] model_word(input int k, input int eff);
        if (k > MAXS) return rotl(PAT, (eff % MAXS) + 1);
        return rotl(PAT, (k - eff + 10) % 10);
    endfunction

    function automatic logic [9:0] bad_word();
        logic [9:0] v;
        do v = 10'($urandom); while (v == PAT);
        return v;
    endfunction

    task automatic run_align(input int k);
        int  nslip, fin, eff;
        bit  exp_bs;
        int  pulses[$];
        nslip = (k > MAXS) ? MAXS : k;
        fin = (k > MAXS) ? (1 + S + MAXS * (S + 2) + 1) : (1 + S + k * (S + 2) + M);
        exp_err1 = 0;
        start1 = 1'b1;
        word1 = model_word(k, 0);
        @(negedge clk);
        start1 = 1'b0;
        check_eq("start_slip_clr", 32'(slip1), 0);
        check_eq("start_err_clr", 32'(err1), 0);
        for (int n = 1; n <= fin; n++) begin
            exp_bs = (n >= S + 2) && ((n - (S + 2)) % (S + 2) == 0) &&
                     ((n - (S + 2)) / (S + 2) < nslip);
            check_eq("bitslip", 32'(bs1), 32'(exp_bs));
            check_eq("busy", 32'(busy1), 32'(n < fin));
            check_eq("aligned", 32'(al1), 32'(k <= MAXS && n == fin));
            check_eq("failed", 32'(fail1), 32'(k > MAXS && n == fin));
            if (bs1) pulses.push_back(n);
            if (n < fin) begin
                eff = 0;
                foreach (pulses[i]) if (pulses[i] <= n - 2) eff++;
                word1 = model_word(k, eff);
                @(negedge clk);
            end
        end
        check_eq("slip_count_end", 32'(slip1), 32'(nslip));
        check_eq("pulse_total", 32'(pulses.size()), 32'(nslip));
        for (int i = 1; i < pulses.size(); i++)
            check_eq("pulse_spacing", 32'(pulses[i] - pulses[i-1] >= S + 2), 1);
    endtask

    task automatic locked_stream();
        int loss = 0;
        bit b;
        bit dropped = 0;
        while (inj_q.size() > 0 && !dropped) begin
            b = inj_q.pop_front();
            word1 = b ? bad_word() : PAT;
            @(negedge clk);
            if (b) begin
                if (exp_err1 < 16'hffff) exp_err1++;
                loss++;
            end else begin
                loss = 0;
            end
            check_eq("lock_err", 32'(err1), 32'(exp_err1));
            if (loss == T) begin
                dropped = 1;
                check_eq("loss_aligned", 32'(al1), 0);
                check_eq("loss_busy", 32'(busy1), 1);
                check_eq("loss_slip", 32'(slip1), 0);
            end else begin
                check_eq("lock_aligned", 32'(al1), 1);
            end
        end
        inj_q.delete();
        if (dropped) begin
            for (int i = 0; i < M; i++) begin
                word1 = PAT;
                @(negedge clk);
                check_eq("relock_aligned", 32'(al1), 32'(i == M - 1));
                check_eq("relock_busy", 32'(busy1), 32'(i != M - 1));
            end
        end
        word1 = PAT;
    endtask

    task automatic seq_dut1();
        int k, len;
        bit got;
        rst1 = 1'b1; start1 = 1'b0; word1 = PAT;
        @(negedge clk);
        check_eq("rst_bitslip", 32'(bs1), 0);
        check_eq("rst_busy", 32'(busy1), 0);
        check_eq("rst_aligned", 32'(al1), 0);
        check_eq("rst_failed", 32'(fail1), 0);
        check_eq("rst_slip", 32'(slip1), 0);
        check_eq("rst_err", 32'(err1), 0);
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);

        run_align(0);
        inj_q = '{1, 1, 1, 0, 1, 1, 1, 1};
        locked_stream();
        check_eq("burst_err_total", 32'(err1), 7);
        run_align(3);
        run_align(10);
        run_align(0);

        repeat (5) begin
            k = $urandom_range(0, 10);
            run_align(k);
            if (k <= MAXS) begin
                len = $urandom_range(10, 40);
                for (int i = 0; i < len; i++) inj_q.push_back(1'($urandom_range(0, 1)));
                locked_stream();
            end
        end

        start1 = 1'b1;
        word1 = bad_word();
        @(negedge clk);
        start1 = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bs1) got = 1;
            else @(negedge clk);
        end
        check_eq("reset_saw_slip", 32'(got), 1);
        #1 rst1 = 1'b1;
        #1;
        check_eq("async_bitslip", 32'(bs1), 0);
        check_eq("async_busy", 32'(busy1), 0);
        check_eq("async_aligned", 32'(al1), 0);
        check_eq("async_failed", 32'(fail1), 0);
        check_eq("async_slip", 32'(slip1), 0);
        start1 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("start_in_reset", 32'(busy1), 0);
        rst1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        check_eq("start_at_release", 32'(busy1), 0);
        @(negedge clk);
        check_eq("idle_after_release", 32'(busy1), 0);
        run_align(0);
    endtask

    task automatic seq_dut2();
        bit got;
        rst2 = 1'b1; start2 = 1'b0; word2 = PAT;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (al2) got = 1;
            else @(negedge clk);
        end
        check_eq("d2_lock", 32'(got), 1);
        for (int g = 0; g < 4681; g++) begin
            for (int i = 0; i < 15; i++) begin
                word2 = (i < 14) ? bad_word() : PAT;
                @(negedge clk);
            end
            check_eq("d2_err", 32'(err2), 32'(14 * (g + 1)));
            check_eq("d2_aligned", 32'(al2), 1);
        end
        check_eq("d2_fffe", 32'(err2), 32'hfffe);
        for (int i = 0; i < 3; i++) begin
            word2 = bad_word();
            @(negedge clk);
            check_eq("d2_saturate", 32'(err2), 32'hffff);
        end
        word2 = PAT;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        start1 = 1'b0; start2 = 1'b0;
        word1 = PAT; word2 = PAT;
        fork
            seq_dut1();
            seq_dut2();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
